// File: rtl/crono_ctrl.sv
// Stopwatch controller: start/stop/lap/clear sequencing, a one-second
// prescaler, a four-digit MM:SS BCD counter and the display-mode select.
// Every output comes straight from a flop.
module crono_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       btn_mode,
    output logic [3:0] uns,
    output logic [3:0] des,
    output logic [3:0] unm,
    output logic [3:0] dem,
    output logic       fg,
    output logic       j,
    output logic       running,
    output logic       ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    uns_q, uns_d, des_q, des_d, unm_q, unm_d, dem_q, dem_d;
    logic          ovf_q, ovf_d;
    logic          fg_q, running_q, j_q;
    logic          counting, tick, clear_now;

    assign counting  = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick      = counting && (presc_q == PRESC_MAX);
    // A clear is only honoured from PAUSE, and beats a simultaneous start.
    assign clear_now = (state_q == S_PAUSE) && btn_clear;

    // Next prescaler and BCD digits; the carry ripples only on a tick.
    always_comb begin
        presc_d = presc_q;
        uns_d   = uns_q;
        des_d   = des_q;
        unm_d   = unm_q;
        dem_d   = dem_q;
        ovf_d   = 1'b0;
        if (tick) begin
            presc_d = '0;
            if (uns_q == 4'd9) begin
                uns_d = 4'd0;
                if (des_q == 4'd5) begin
                    des_d = 4'd0;
                    if (unm_q == 4'd9) begin
                        unm_d = 4'd0;
                        if (dem_q == 4'd5) begin
                            dem_d = 4'd0;
                            ovf_d = 1'b1;
                        end else begin
                            dem_d = dem_q + 4'd1;
                        end
                    end else begin
                        unm_d = unm_q + 4'd1;
                    end
                end else begin
                    des_d = des_q + 4'd1;
                end
            end else begin
                uns_d = uns_q + 4'd1;
            end
        end else if (counting) begin
            presc_d = presc_q + 1'b1;
        end
        if (state_q == S_IDLE || clear_now) begin
            presc_d = '0;
            uns_d   = 4'd0;
            des_d   = 4'd0;
            unm_d   = 4'd0;
            dem_d   = 4'd0;
        end
    end

    // Datapath registers: prescaler, digits and the wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            uns_q   <= 4'd0;
            des_q   <= 4'd0;
            unm_q   <= 4'd0;
            dem_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            uns_q   <= uns_d;
            des_q   <= des_d;
            unm_q   <= unm_d;
            dem_q   <= dem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sequencing FSM; fg and running are set together with each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fg_q      <= 1'b1;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_start) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (btn_start) begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                    end else if (btn_lap) begin
                        state_q <= S_LAP;
                        fg_q    <= 1'b0;
                    end
                end
                S_LAP: begin
                    if (btn_start) begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                        fg_q      <= 1'b1;
                    end else if (btn_lap) begin
                        state_q <= S_RUN;
                        fg_q    <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (btn_clear) begin
                        state_q <= S_IDLE;
                    end else if (btn_start) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    fg_q      <= 1'b1;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Display-source select toggles on every mode pulse, in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            j_q <= 1'b0;
        end else if (btn_mode) begin
            j_q <= ~j_q;
        end
    end

    assign uns     = uns_q;
    assign des     = des_q;
    assign unm     = unm_q;
    assign dem     = dem_q;
    assign fg      = fg_q;
    assign j       = j_q;
    assign running = running_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_crono_ctrl.sv
// Bench for crono_ctrl: elapsed time is modelled as a plain seconds count
// and the expected digits are derived from it by division every cycle.
module tb_crono_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
    logic [3:0] uns, des, unm, dem;
    logic       fg, j, running, ovf;

    crono_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_lap(btn_lap),
        .btn_clear(btn_clear), .btn_mode(btn_mode),
        .uns(uns), .des(des), .unm(unm), .dem(dem),
        .fg(fg), .j(j), .running(running), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 run, 2 lap, 3 pause
    int m_st = 0, m_secs = 0, m_pre = 0;
    bit m_j = 0, m_ovf = 0;
    int vectors = 0, miscompares = 0;

    task automatic model_update(bit s, bit l, bit c, bit m, bit r);
        bit run;
        run = (m_st == 1 || m_st == 2);
        if (r) begin
            m_st = 0; m_secs = 0; m_pre = 0; m_j = 0; m_ovf = 0;
            return;
        end
        m_ovf = 0;
        if (run) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                if (m_secs == 3599) begin m_secs = 0; m_ovf = 1; end
                else m_secs++;
            end else begin
                m_pre++;
            end
        end
        case (m_st)
            0: if (s) m_st = 1;
            1: if (s) m_st = 3; else if (l) m_st = 2;
            2: if (s) m_st = 3; else if (l) m_st = 1;
            default: if (c) begin m_st = 0; m_secs = 0; m_pre = 0; end
                     else if (s) m_st = 1;
        endcase
        if (m) m_j = ~m_j;
    endtask

    task automatic cmp(string name, int act, int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0d expected %0d", name, vectors, act, exp);
        end
    endtask

    // One cycle: drive, clock, advance model, compare everything.
    task automatic step(bit s, bit l, bit c, bit m, bit r);
        btn_start = s; btn_lap = l; btn_clear = c; btn_mode = m; rst = r;
        @(posedge clk);
        model_update(s, l, c, m, r);
        #1;
        vectors++;
        cmp("uns", int'(uns), m_secs % 10);
        cmp("des", int'(des), (m_secs % 60) / 10);
        cmp("unm", int'(unm), (m_secs / 60) % 10);
        cmp("dem", int'(dem), m_secs / 600);
        cmp("fg", int'(fg), (m_st == 2) ? 0 : 1);
        cmp("running", int'(running), (m_st == 1 || m_st == 2) ? 1 : 0);
        cmp("j", int'(j), int'(m_j));
        cmp("ovf", int'(ovf), int'(m_ovf));
        $display("vec %0d s%0b l%0b c%0b m%0b r%0b -> %0d%0d:%0d%0d fg=%0b j=%0b run=%0b ovf=%0b",
                 vectors, s, l, c, m, r, dem, unm, des, uns, fg, j, running, ovf);
    endtask

    task automatic idle_n(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Advance with no buttons until the model reaches secs (and prescaler if pre>=0).
    task automatic run_to(int secs, int pre, int limit);
        int k;
        k = 0;
        while (!(m_secs == secs && (pre < 0 || m_pre == pre)) && k < limit) begin
            step(0, 0, 0, 0, 0);
            k++;
        end
        if (k >= limit) begin
            miscompares++;
            $display("FAIL run_to timeout: got secs %0d expected %0d", m_secs, secs);
        end
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        cmp("lit_rst_fg", int'(fg), 1);
        cmp("lit_rst_run", int'(running), 0);
        cmp("lit_rst_uns", int'(uns), 0);

        // Start at edge 0, first tick at edge 4, 00:10 at edge 40
        step(1, 0, 0, 0, 0);
        cmp("lit_start_running", int'(running), 1);
        idle_n(3);
        cmp("lit_uns_before_tick", int'(uns), 0);
        idle_n(1);
        cmp("lit_uns_edge4", int'(uns), 1);
        idle_n(36);
        cmp("lit_des_edge40", int'(des), 1);
        cmp("lit_uns_edge40", int'(uns), 0);

        // Wrap 59:59 -> 00:00
        run_to(3599, -1, 16000);
        cmp("lit_dem_5959", int'(dem), 5);
        cmp("lit_unm_5959", int'(unm), 9);
        run_to(0, -1, 10);
        cmp("lit_ovf_wrap", int'(ovf), 1);
        cmp("lit_run_wrap", int'(running), 1);
        step(0, 0, 0, 0, 0);
        cmp("lit_ovf_one_cycle", int'(ovf), 0);

        // Lap freeze/release
        run_to(5, 0, 100);
        step(0, 1, 0, 0, 0);
        cmp("lit_lap_fg0", int'(fg), 0);
        run_to(8, 0, 100);
        step(0, 1, 0, 0, 0);
        cmp("lit_lap_fg1", int'(fg), 1);
        cmp("lit_lap_uns8", int'(uns), 8);
        run_to(9, 0, 100);
        cmp("lit_continue_uns9", int'(uns), 9);

        // Pause with prescaler 2, hold, resume, clear
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        run_to(3, 1, 100);
        step(1, 0, 0, 0, 0);
        idle_n(20);
        cmp("lit_pause_uns3", int'(uns), 3);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp("lit_resume_uns3", int'(uns), 3);
        step(0, 0, 0, 0, 0);
        cmp("lit_resume_uns4", int'(uns), 4);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        cmp("lit_clear_uns", int'(uns), 0);
        cmp("lit_clear_run", int'(running), 0);

        // Priorities
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        cmp("lit_clear_in_run", int'(running), 1);
        step(1, 1, 0, 0, 0);
        cmp("lit_start_lap_fg", int'(fg), 1);
        cmp("lit_start_lap_run", int'(running), 0);
        step(1, 0, 1, 0, 0);
        cmp("lit_clear_start_idle", int'(running), 0);
        idle_n(6);

        // Mode toggles in IDLE, RUN, LAP
        step(0, 0, 0, 1, 0);
        cmp("lit_j_idle1", int'(j), 1);
        step(0, 0, 0, 1, 0);
        cmp("lit_j_idle0", int'(j), 0);
        step(1, 0, 0, 1, 0);
        cmp("lit_j_run1", int'(j), 1);
        step(0, 1, 0, 1, 0);
        cmp("lit_j_lap0", int'(j), 0);
        step(0, 0, 0, 1, 0);
        cmp("lit_j_lap1", int'(j), 1);

        // Randomized button traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 399) == 0));
        end

        // Reset mid-RUN at 12:34
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0);
        run_to(754, -1, 4000);
        cmp("lit_1234_dem", int'(dem), 1);
        cmp("lit_1234_uns", int'(uns), 4);
        step(1, 1, 0, 1, 1);
        cmp("lit_rst_uns2", int'(uns), 0);
        cmp("lit_rst_unm2", int'(unm), 0);
        cmp("lit_rst_j2", int'(j), 0);
        cmp("lit_rst_run2", int'(running), 0);
        cmp("lit_rst_fg2", int'(fg), 1);
        idle_n(4);
        cmp("lit_rst_idle_hold", int'(uns), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
